game_countdown: RTL and testbench

Countdown timer that runs the opposite direction of the game's elapsed-seconds timer: software or game logic loads a starting number of seconds, starts it, and the block decrements once per second of `clk25` until zero. It drives the round-timer display with a binary count and three BCD digits, plus pulses for the game FSM (one per second, one on expiry). It sits beside the elapsed timer in the game core, on the same 25 MHz domain.

---
 rtl/game_countdown_pkg.sv | 37 +++
 rtl/game_countdown_bin2bcd.sv | 54 +++++
 rtl/game_countdown.sv | 128 ++++++++++++
 tb/tb_game_countdown.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/game_countdown_pkg.sv
// Shared game-core types and constants: countdown FSM states, BCD digit
// triple and the borrow-decrement used on the round-timer display.
package game_countdown_pkg;

  localparam int CLK25_HZ = 25_000_000;

  typedef enum logic [2:0] {
    CD_IDLE,
    CD_CONVERT,
    CD_RUN,
    CD_PAUSE,
    CD_EXPIRED
  } cd_state_t;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

  // Caller guarantees a nonzero value, so the hundreds digit never wraps.
  function automatic bcd3_t bcd_dec(input bcd3_t v);
    bcd3_t r;
    r = v;
    if (v.ones != 4'd0) r.ones = v.ones - 4'd1;
    else begin
      r.ones = 4'd9;
      if (v.tens != 4'd0) r.tens = v.tens - 4'd1;
      else begin
        r.tens = 4'd9;
        r.hund = v.hund - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_countdown_bin2bcd.sv
// Sequential double-dabble: one shift-add-3 step per cycle, SEC_W cycles.
// Digit outputs are the result of the current step; valid while done is high.
module bin2bcd_seq
  import game_countdown_pkg::*;
#(
  parameter int SEC_W = 8
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic             start,
  input  logic [SEC_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_hund,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  localparam int CW = $clog2(SEC_W + 1);

  logic [SEC_W-1:0] sh;
  logic [CW-1:0]    cnt;
  bcd3_t            acc, acc_adj, acc_nxt;

  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < 3; d++)
      if (acc[d*4 +: 4] >= 4'd5) acc_adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
    acc_nxt = 12'({acc_adj, sh[SEC_W-1]});
  end

  assign done = busy && (cnt == CW'(SEC_W - 1));
  assign {bcd_hund, bcd_tens, bcd_ones} = acc_nxt;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sh   <= bin;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      sh  <= sh << 1;
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/game_countdown.sv
// Round countdown timer: loads seconds, converts to BCD, then decrements
// once per CLK_HZ cycles with BCD borrow, pulsing tick and expire_pulse.
module game_countdown
  import game_countdown_pkg::*;
#(
  parameter int CLK_HZ = CLK25_HZ,
  parameter int SEC_W  = 8
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic             load,
  input  logic [SEC_W-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [SEC_W-1:0] seconds_left,
  output logic [3:0]       bcd_hund,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             busy,
  output logic             running,
  output logic             tick,
  output logic             expired,
  output logic             expire_pulse
);

  localparam int            PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_TOP = PW'(CLK_HZ - 1);

  logic [1:0]       rst_ff;
  logic             rst_n;
  cd_state_t        state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [SEC_W-1:0] cnt_nxt;
  bcd3_t            bcd, bcd_nxt;
  logic [3:0]       conv_h, conv_t, conv_o;
  logic             conv_done, tick_nxt, xp_nxt;

  // Assert asynchronously, release two edges later in the clk25 domain.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) rst_ff <= 2'b00;
    else          rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_n = rst_ff[1];

  bin2bcd_seq #(.SEC_W(SEC_W)) u_bcd (
    .clk25    (clk25),
    .reset_n  (rst_n),
    .start    (load),
    .bin      (load_value),
    .busy     (busy),
    .done     (conv_done),
    .bcd_hund (conv_h),
    .bcd_tens (conv_t),
    .bcd_ones (conv_o)
  );

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    cnt_nxt   = seconds_left;
    bcd_nxt   = bcd;
    tick_nxt  = 1'b0;
    xp_nxt    = 1'b0;
    if (load) begin
      state_nxt = CD_CONVERT;
      presc_nxt = '0;
      cnt_nxt   = load_value;
    end else begin
      case (state)
        CD_CONVERT:
          if (conv_done) begin
            state_nxt = CD_IDLE;
            bcd_nxt   = '{hund: conv_h, tens: conv_t, ones: conv_o};
          end
        CD_IDLE:
          if (start && !pause) begin
            presc_nxt = '0;
            if (seconds_left == '0) begin
              state_nxt = CD_EXPIRED;
              xp_nxt    = 1'b1;
            end else state_nxt = CD_RUN;
          end
        CD_RUN, CD_PAUSE:
          // The resume edge counts, so a P-cycle pause shifts ticks by exactly P.
          if (pause) state_nxt = CD_PAUSE;
          else begin
            state_nxt = CD_RUN;
            if (presc == PS_TOP) begin
              presc_nxt = '0;
              cnt_nxt   = seconds_left - 1'b1;
              bcd_nxt   = bcd_dec(bcd);
              tick_nxt  = 1'b1;
              if (seconds_left == SEC_W'(1)) begin
                state_nxt = CD_EXPIRED;
                xp_nxt    = 1'b1;
              end
            end else presc_nxt = presc + 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CD_IDLE;
      presc        <= '0;
      seconds_left <= '0;
      bcd          <= '0;
      tick         <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      presc        <= presc_nxt;
      seconds_left <= cnt_nxt;
      bcd          <= bcd_nxt;
      tick         <= tick_nxt;
      expire_pulse <= xp_nxt;
    end
  end

  assign bcd_hund = bcd.hund;
  assign bcd_tens = bcd.tens;
  assign bcd_ones = bcd.ones;
  assign running  = (state == CD_RUN);
  assign expired  = (state == CD_EXPIRED);

endmodule

// File: tb/tb_game_countdown.sv
// Scoreboard bench for game_countdown at CLK_HZ=4: tick/expiry events are
// queued when start is driven and checked as the DUT emits them.
module tb_game_countdown;

  localparam int HZ = 4;

  logic       clk25 = 1'b0, reset_n = 1'b0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] load_value = '0;
  logic [7:0] seconds_left;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;
  logic       busy, running, tick, expired, expire_pulse;

  int n_cmp = 0, n_err = 0, cyc = 0;

  typedef struct {
    int   cyc;
    int   secs;
    logic tick;
    logic xp;
  } ev_t;
  ev_t sb[$];

  game_countdown #(.CLK_HZ(HZ), .SEC_W(8)) dut (
    .clk25(clk25), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .seconds_left(seconds_left),
    .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .busy(busy), .running(running), .tick(tick), .expired(expired),
    .expire_pulse(expire_pulse)
  );

  initial forever #5 clk25 = ~clk25;
  always @(posedge clk25) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = 8'(v);
    step(1);
    load = 1'b0;
  endtask

  // Queue the expected events for a start sampled at the next edge.
  task automatic do_start(input int n, input int dly, input int nev);
    int s;
    s = cyc + 1;
    if (n == 0) sb.push_back('{s, 0, 1'b0, 1'b1});
    else for (int k = 1; k <= nev; k++) sb.push_back('{s + HZ*k + dly, n - k, 1'b1, (n - k) == 0});
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  always @(negedge clk25) begin
    ev_t e;
    if (tick || expire_pulse) begin
      if (sb.size() == 0) chk("unexpected_evt", {tick, expire_pulse}, 0);
      else begin
        e = sb.pop_front();
        chk("evt_cycle", cyc, e.cyc);
        chk("evt_secs", seconds_left, e.secs);
        chk("evt_bcd", {bcd_hund, bcd_tens, bcd_ones}, to_bcd(e.secs));
        chk("evt_tick", tick, e.tick);
        chk("evt_expire_pulse", expire_pulse, e.xp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int nb, np;
    step(2);
    chk("rst_outputs", {seconds_left, bcd_hund, bcd_tens, bcd_ones, busy, running,
                        tick, expired, expire_pulse}, 0);
    reset_n = 1'b1;
    step(3);

    // Load 123: busy window and BCD update timing
    do_load(123);
    chk("ld123_secs", seconds_left, 123);
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) chk("ld123_bcd_old", {bcd_hund, bcd_tens, bcd_ones}, 12'h000);
      if (i == 8) chk("ld123_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h123);
      nb += int'(busy);
      step(1);
    end
    chk("ld123_busy_len", nb, 8);

    // Load 3 and run to expiry
    do_load(3); step(8);
    do_start(3, 0, 3);
    chk("run3_running", running, 1);
    step(HZ*3 + 2);
    chk("run3_secs", seconds_left, 0);
    chk("run3_expired", expired, 1);
    chk("run3_running_off", running, 0);
    step(3);
    chk("run3_expired_hold", expired, 1);

    // Load 100: borrow across two digits on the first tick, then run out
    do_load(100); step(8);
    chk("ld100_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h100);
    do_start(100, 0, 100);
    step(HZ*100 + 2);
    chk("run100_expired", expired, 1);

    // Load 5, pause for 10 cycles at prescaler 2
    do_load(5); step(8);
    do_start(5, 10, 5);
    step(2);
    pause = 1'b1;
    np = 0;
    repeat (10) begin
      step(1);
      np += int'(running);
    end
    pause = 1'b0;
    chk("pause_running", np, 0);
    step(1);
    chk("resume_running", running, 1);
    step(HZ*5 + 2);
    chk("pause_expired", expired, 1);

    // Load 0 then start: immediate expiry, no tick
    do_load(0); step(8);
    chk("ld0_expired_clear", expired, 0);
    do_start(0, 0, 0);
    chk("zero_expired", expired, 1);
    chk("zero_running", running, 0);
    step(2);

    // Load 9, run, reload 7 on the wrap edge
    do_load(9); step(8);
    do_start(9, 0, 0);
    step(HZ - 1);
    load = 1'b1; load_value = 8'd7;
    step(1);
    load = 1'b0;
    chk("reload_secs", seconds_left, 7);
    chk("reload_tick", tick, 0);
    chk("reload_busy", busy, 1);
    chk("reload_running", running, 0);
    step(8);
    chk("reload_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h007);
    chk("reload_idle_busy", busy, 0);
    step(10);

    // Asynchronous reset in the middle of RUN, while tick is high
    do_load(50); step(8);
    do_start(50, 0, 1);
    step(HZ);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_rst_outputs", {seconds_left, bcd_hund, bcd_tens, bcd_ones, busy, running,
                               tick, expired, expire_pulse}, 0);
    step(3);
    chk("midrun_rst_hold", {expired, expire_pulse, running}, 0);
    reset_n = 1'b1;
    step(3);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
